// File: rtl/gpio_cmd_frontend.sv
// GPIO command decoder for the conv/memory core: kernel, length, image-write and readout strobes plus LOAD/RUN/DONE sequencing.
// Optional GPIO_STATUS_EN adds state, sticky error and first-frame flags to the readback word.
module gpio_cmd_frontend #(
  parameter int GPIO_D = 32,
  parameter int N      = 4,
  parameter int ADDR_W = 10,
  parameter int KER_W  = 24,
  parameter int DATA_W = 13
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [GPIO_D-1:0]         i_gpio_data,
  output logic [GPIO_D-1:0]         o_gpio_data,
  output logic                      o_led,
  output logic                      o_ker_we,
  output logic [1:0]                o_ker_idx,
  output logic [KER_W-1:0]          o_ker_data,
  output logic [ADDR_W-1:0]         o_img_len,
  output logic                      o_mem_we,
  output logic [$clog2(N+2)-1:0]    o_mem_sel,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [7:0]                o_mem_data,
  output logic                      o_first,
  output logic                      o_start,
  input  logic                      i_done,
  output logic [$clog2(N)-1:0]      o_rd_sel,
  output logic [ADDR_W-1:0]         o_rd_addr,
  input  logic [DATA_W-1:0]         i_rd_data
);

  localparam int SEL_W = $clog2(N+2);
  localparam int RS_W  = $clog2(N);

  localparam logic [2:0] CMD_KER  = 3'b000;
  localparam logic [2:0] CMD_LEN  = 3'b001;
  localparam logic [2:0] CMD_IMG  = 3'b010;
  localparam logic [2:0] CMD_READ = 3'b011;
  localparam logic [2:0] CMD_LAST = 3'b100;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic              rst;
  logic [2:0]        ctrl;
  logic              valid;
  logic              valid_q;
  logic              accept;
  logic [KER_W-1:0]  data;
  logic              last_pend;
  logic              do_ker, do_img, do_last, do_read, read_last;
  logic              addr_wrap;
  logic [SEL_W-1:0]  sel_top;
  logic [GPIO_D-1:0] readback;
  logic              unused_bits;

  assign rst         = i_reset | i_gpio_data[0];
  assign ctrl        = i_gpio_data[GPIO_D-1 -: 3];
  assign valid       = i_gpio_data[GPIO_D-4];
  assign data        = i_gpio_data[KER_W:1];
  assign accept      = valid & ~valid_q;
  assign unused_bits = ^i_gpio_data[GPIO_D-5:KER_W+1];

  always_comb begin
    do_ker    = accept && (state == LOAD) && (ctrl == CMD_KER);
    do_img    = accept && (state == LOAD) && (ctrl == CMD_IMG);
    do_last   = accept && (state == LOAD) && (ctrl == CMD_LAST);
    do_read   = accept && (state == DONE) && (ctrl == CMD_READ);
    // Lengths below 2 leave no readable column, so the first READ ends the frame.
    read_last = do_read && ((o_img_len < ADDR_W'(2)) ||
                            ((o_rd_sel == RS_W'(N-1)) && (o_rd_addr == o_img_len - ADDR_W'(2))));
    addr_wrap = (o_mem_addr == o_img_len);
    sel_top   = o_first ? SEL_W'(N+1) : SEL_W'(N-1);
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (last_pend) state_next = RUN;
      RUN:     if (i_done)    state_next = DONE;
      DONE:    if (read_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

`ifdef GPIO_STATUS_EN
  logic err;
  logic ignored;

  assign ignored = accept && !(do_ker || do_img || do_last || do_read ||
                               ((state == LOAD) && (ctrl == CMD_LEN)));

  always_ff @(posedge i_clock) begin
    if (rst)          err <= 1'b0;
    else if (ignored) err <= 1'b1;
  end
`endif

  always_comb begin
    readback               = '0;
    readback[DATA_W-1:0]   = i_rd_data;
`ifdef GPIO_STATUS_EN
    readback[GPIO_D-1 -: 2] = state;
    readback[GPIO_D-3]      = err;
    readback[GPIO_D-4]      = o_first;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (rst) begin
      valid_q     <= 1'b0;
      last_pend   <= 1'b0;
      o_gpio_data <= '0;
      o_led       <= 1'b0;
      o_ker_we    <= 1'b0;
      o_ker_idx   <= 2'd0;
      o_ker_data  <= '0;
      o_img_len   <= '0;
      o_mem_we    <= 1'b0;
      o_mem_sel   <= '0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_first     <= 1'b1;
      o_start     <= 1'b0;
      o_rd_sel    <= '0;
      o_rd_addr   <= '0;
    end else begin
      valid_q     <= valid;
      o_gpio_data <= readback;
      o_led       <= (state_next == DONE);

      o_ker_we <= do_ker;
      if (do_ker) o_ker_data <= data;
      // Index advances after the pulse so the write sees the pre-increment row.
      if (o_ker_we) o_ker_idx <= (o_ker_idx == 2'd2) ? 2'd0 : o_ker_idx + 2'd1;

      // Length is level-decoded: software may just park ctrl=001 with the value.
      if ((state == LOAD) && (ctrl == CMD_LEN)) o_img_len <= i_gpio_data[ADDR_W:1];

      o_mem_we  <= do_img | do_last;
      last_pend <= do_last;
      if (do_img || do_last) o_mem_data <= data[7:0];
      if (o_mem_we) begin
        if (last_pend) begin
          o_mem_sel  <= '0;
          o_mem_addr <= '0;
        end else if (addr_wrap) begin
          o_mem_addr <= '0;
          o_mem_sel  <= (o_mem_sel == sel_top) ? '0 : o_mem_sel + SEL_W'(1);
        end else begin
          o_mem_addr <= o_mem_addr + ADDR_W'(1);
        end
      end
      o_start <= last_pend;

      if (do_read) begin
        if (read_last) begin
          o_rd_sel  <= '0;
          o_rd_addr <= '0;
          o_first   <= 1'b0;
        end else if (o_rd_addr == o_img_len - ADDR_W'(2)) begin
          o_rd_addr <= '0;
          o_rd_sel  <= o_rd_sel + RS_W'(1);
        end else begin
          o_rd_addr <= o_rd_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_cmd_frontend.sv
// Randomized self-checking bench for gpio_cmd_frontend; expectations come from frame arithmetic, not the RTL structure.
module tb_gpio_cmd_frontend;
  localparam int N      = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 13;

  localparam logic [2:0] C_KER  = 3'b000;
  localparam logic [2:0] C_LEN  = 3'b001;
  localparam logic [2:0] C_IMG  = 3'b010;
  localparam logic [2:0] C_READ = 3'b011;
  localparam logic [2:0] C_LAST = 3'b100;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       gpio;
  logic [31:0]       gpio_out;
  logic              led, ker_we, mem_we, first, start, done;
  logic [1:0]        ker_idx;
  logic [23:0]       ker_data;
  logic [ADDR_W-1:0] img_len, mem_addr, rd_addr;
  logic [2:0]        mem_sel;
  logic [7:0]        mem_data;
  logic [1:0]        rd_sel;
  logic [DATA_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;
  int ker_cnt = 0, mem_cnt = 0, start_cnt = 0;
  int exp_starts = 0;
  int ker_model = 0;
  bit model_first = 1'b1;

`ifdef GPIO_STATUS_EN
  localparam logic [31:0] RB_MASK = 32'h0000_1FFF;
`else
  localparam logic [31:0] RB_MASK = 32'hFFFF_FFFF;
`endif

  always #5 clk = ~clk;

  gpio_cmd_frontend dut (
    .i_clock(clk), .i_reset(reset), .i_gpio_data(gpio), .o_gpio_data(gpio_out),
    .o_led(led), .o_ker_we(ker_we), .o_ker_idx(ker_idx), .o_ker_data(ker_data),
    .o_img_len(img_len), .o_mem_we(mem_we), .o_mem_sel(mem_sel), .o_mem_addr(mem_addr),
    .o_mem_data(mem_data), .o_first(first), .o_start(start), .i_done(done),
    .o_rd_sel(rd_sel), .o_rd_addr(rd_addr), .i_rd_data(rd_data)
  );

  function automatic logic [DATA_W-1:0] rd_model(input int s, input int a);
    return DATA_W'((s * 613) ^ (a * 29) ^ 165);
  endfunction

  always_comb rd_data = rd_model(int'(rd_sel), int'(rd_addr));

  always @(posedge clk) begin
    if (ker_we) ker_cnt   <= ker_cnt + 1;
    if (mem_we) mem_cnt   <= mem_cnt + 1;
    if (start)  start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic v, input logic [23:0] d);
    gpio = {c, v, 3'b000, d, 1'b0};
  endtask

  // Raise valid; return at the negedge after the accepting edge.
  task automatic pulse(input logic [2:0] c, input logic [23:0] d);
    drive(c, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_valid();
    gpio[28] = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_kernel(input logic [23:0] d);
    pulse(C_KER, d);
    check("ker_we", 32'(ker_we), 32'd1);
    check("ker_idx", 32'(ker_idx), 32'(ker_model));
    check("ker_data", 32'(ker_data), 32'(d));
    release_valid();
    ker_model = (ker_model + 1) % 3;
    $display("kernel row data=%06h idx_after=%0d", d, ker_idx);
  endtask

  task automatic send_illegal();
    logic [2:0] codes [4];
    codes = '{3'b011, 3'b101, 3'b110, 3'b111};
    pulse(codes[$urandom_range(0, 3)], 24'($urandom));
    check("illegal_mem_we", 32'(mem_we), 32'd0);
    check("illegal_ker_we", 32'(ker_we), 32'd0);
    release_valid();
  endtask

  task automatic write_pixel(input int k, input int len, input logic [2:0] c);
    logic [23:0] d;
    d = 24'($urandom);
    pulse(c, d);
    check("mem_we", 32'(mem_we), 32'd1);
    check("mem_sel", 32'(mem_sel), 32'(k / (len + 1)));
    check("mem_addr", 32'(mem_addr), 32'(k % (len + 1)));
    check("mem_data", 32'(mem_data), 32'(d[7:0]));
  endtask

  task automatic hold_and_toggle(input int len);
    int c0, k0;
    logic [2:0] tog [4];
    tog = '{C_IMG, C_LAST, C_KER, C_READ};
    c0 = mem_cnt;
    repeat (49) @(negedge clk);
    release_valid();
    check("hold_single_write", 32'(mem_cnt - c0), 32'd1);
    c0 = mem_cnt;
    k0 = ker_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(tog[i % 4], 1'b0, 24'($urandom));
      @(negedge clk);
    end
    drive(C_LEN, 1'b0, 24'(len));
    repeat (2) @(negedge clk);
    check("toggle_no_mem_we", 32'(mem_cnt - c0), 32'd0);
    check("toggle_no_ker_we", 32'(ker_cnt - k0), 32'd0);
    check("toggle_len_kept", 32'(img_len), 32'(len));
    $display("hold valid 50 cycles and ctrl toggles: writes=%0d", mem_cnt - c0 + 1);
  endtask

  task automatic run_frame(input int len, input bit edge_len, input bit hold_test);
    int m, w, nr, s, a, base;
    if (edge_len) begin
      pulse(C_LEN, 24'(len));
      release_valid();
    end else begin
      drive(C_LEN, 1'b0, 24'(len));
      repeat (2) @(negedge clk);
    end
    check("img_len", 32'(img_len), 32'(len));
    m = model_first ? N + 2 : N;
    w = m * (len + 1);
    base = mem_cnt;
    for (int k = 0; k < w; k++) begin
      if ($urandom_range(0, 31) == 0) send_illegal();
      write_pixel(k, len, (k == w - 1) ? C_LAST : C_IMG);
      if (hold_test && k == 50) hold_and_toggle(len);
      else release_valid();
    end
    exp_starts++;
    check("start_pulse", 32'(start), 32'd1);
    @(negedge clk);
    check("start_once", 32'(start), 32'd0);
    check("start_cnt", 32'(start_cnt), 32'(exp_starts));
    check("mem_write_cnt", 32'(mem_cnt - base), 32'(w));
    check("sel_cleared", 32'(mem_sel), 32'd0);
    check("addr_cleared", 32'(mem_addr), 32'd0);
    $display("frame L=%0d first=%0d writes=%0d starts=%0d", len, model_first, mem_cnt - base, start_cnt);

    pulse(C_READ, 24'd0);
    release_valid();
    pulse(C_KER, 24'($urandom));
    check("run_ker_ignored", 32'(ker_we), 32'd0);
    release_valid();
    check("run_rd_addr", 32'(rd_addr), 32'd0);
    check("run_ker_idx", 32'(ker_idx), 32'(ker_model));
    check("run_led", 32'(led), 32'd0);
`ifdef GPIO_STATUS_EN
    check("status_state_run", 32'(gpio_out[31:30]), 32'd1);
    check("status_err", 32'(gpio_out[29]), 32'd1);
`endif
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("done_led", 32'(led), 32'd1);

    nr = (len < 2) ? 1 : N * (len - 1);
    for (int j = 0; j < nr; j++) begin
      s = (len < 2) ? 0 : j / (len - 1);
      a = (len < 2) ? 0 : j % (len - 1);
      check("rd_sel", 32'(rd_sel), 32'(s));
      check("rd_addr", 32'(rd_addr), 32'(a));
      check("readback", gpio_out & RB_MASK, 32'(rd_model(s, a)));
      check("read_led", 32'(led), 32'd1);
      pulse(C_READ, 24'($urandom));
      if (j == nr - 1) begin
        check("end_led", 32'(led), 32'd0);
        check("end_first", 32'(first), 32'd0);
        check("end_rd_sel", 32'(rd_sel), 32'd0);
        check("end_rd_addr", 32'(rd_addr), 32'd0);
      end
      release_valid();
    end
    model_first = 1'b0;
    $display("readout L=%0d reads=%0d", len, nr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset = 1'b1;
    done  = 1'b0;
    gpio  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_ker_idx", 32'(ker_idx), 32'd0);
    check("rst_first", 32'(first), 32'd1);
    check("rst_mem_sel", 32'(mem_sel), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_img_len", 32'(img_len), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    $display("reset released");

    send_kernel(24'h002000);
    send_kernel(24'h208020);
    send_kernel(24'h002000);
    check("ker_idx_wrapped", 32'(ker_idx), 32'd0);
    check("ker_pulses", 32'(ker_cnt), 32'd3);

    run_frame(439, 1'b0, 1'b1);
    run_frame($urandom_range(2, 12), 1'b1, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(1, 1'b0, 1'b0);

    drive(C_LEN, 1'b0, 24'd150);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      write_pixel(k, 150, C_IMG);
      release_valid();
    end
    check("pre_srst_addr", 32'(mem_addr), 32'd100);
    gpio = 32'h0000_0001;
    repeat (2) @(negedge clk);
    gpio = 32'd0;
    @(negedge clk);
    check("srst_mem_sel", 32'(mem_sel), 32'd0);
    check("srst_mem_addr", 32'(mem_addr), 32'd0);
    check("srst_first", 32'(first), 32'd1);
    check("srst_img_len", 32'(img_len), 32'd0);
    check("srst_ker_idx", 32'(ker_idx), 32'd0);
    check("srst_led", 32'(led), 32'd0);
    repeat (3) @(negedge clk);
    check("srst_no_start", 32'(start_cnt), 32'(exp_starts));
    $display("soft reset mid-image at addr 100");
    model_first = 1'b1;
    ker_model   = 0;

    len = $urandom_range(2, 8);
    run_frame(len, 1'b1, 1'b0);
    send_kernel(24'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
